// File: rtl/snake_dir_if.sv
// Snake direction interface: raw buttons, frame tick and collision in; direction and game_state out.
// master: the direction controller side. slave: the board/game side that drives the buttons and ticks.
interface snake_dir_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_left;
  logic       btn_right;
  logic       update;
  logic [1:0] collision;
  logic [2:0] direction;
  logic [1:0] game_state;

  modport master (
    input  btn_up, btn_down, btn_left, btn_right, update, collision,
    output direction, game_state
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right, update, collision,
    input  direction, game_state
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: synchronises and debounces four buttons, rejects reversals,
// buffers the next turn and applies it on frame ticks, and runs the READY/PLAY/GAME_OVER FSM.
// Optional feature: define SNAKE_DIR_QUEUE_EN for a 2-entry turn FIFO instead of a
// single overwriting pending register.
module snake_dir_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CNT_BIT         = 16,
  parameter int unsigned OVER_HOLD       = 120
) (
  input  logic        clk,
  input  logic        reset,
  snake_dir_if.master bus
);

  localparam int unsigned HOLD_W = $clog2(OVER_HOLD + 1);
`ifdef SNAKE_DIR_QUEUE_EN
  localparam int unsigned QD  = 2;
  localparam int unsigned QCW = 2;
`else
  localparam int unsigned QD  = 1;
  localparam int unsigned QCW = 1;
`endif

  localparam logic [2:0] DIR_IDLE  = 3'd0;
  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_DOWN  = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_RIGHT = 3'd4;

  typedef enum logic [1:0] {
    READY = 2'b00,
    PLAY  = 2'b01,
    OVER  = 2'b11
  } state_t;

  logic [3:0]         raw;
  logic [3:0]         sync1;
  logic [3:0]         sync2;
  logic [3:0]         deb;
  logic [3:0]         deb_q;
  logic [CNT_BIT-1:0] cnt [4];

  logic [3:0]         press_c;
  logic [2:0]         press_dir_c;
  logic [2:0]         newest_c;
  logic [2:0]         ref_c;
  logic               press_ok_c;
  logic               fatal_c;
  logic               push_c;

  state_t             state_q, state_d;
  logic [2:0]         dir_q, dir_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [QCW-1:0]     q_cnt_q, q_cnt_d;
  logic [2:0]         q_dir_q [QD];
  logic [2:0]         q_dir_d [QD];

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_IDLE;
    endcase
  endfunction

  assign raw = {bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // Two-flop synchroniser plus per-button stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] != deb[i]) begin
          if (cnt[i] == CNT_BIT'(DEBOUNCE_CYCLES - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_BIT'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press_c = deb & ~deb_q;

  // Priority encode simultaneous press events: UP > DOWN > LEFT > RIGHT.
  always_comb begin
    press_dir_c = DIR_IDLE;
    if (press_c[0])      press_dir_c = DIR_UP;
    else if (press_c[1]) press_dir_c = DIR_DOWN;
    else if (press_c[2]) press_dir_c = DIR_LEFT;
    else if (press_c[3]) press_dir_c = DIR_RIGHT;
  end

`ifdef SNAKE_DIR_QUEUE_EN
  assign newest_c = q_cnt_q[1] ? q_dir_q[1] : q_dir_q[0];
`else
  assign newest_c = q_dir_q[0];
`endif

  // Reversal check is made against the turn that will be in effect last.
  assign ref_c      = (q_cnt_q != '0) ? newest_c : dir_q;
  assign press_ok_c = (press_dir_c != DIR_IDLE) &&
                      ((ref_c == DIR_IDLE) ||
                       ((press_dir_c != ref_c) && (press_dir_c != opposite(ref_c))));
  assign fatal_c    = (bus.collision == 2'b01) || (bus.collision == 2'b11);

  // Next-state, direction, hold counter and pending-turn update.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    hold_d  = hold_q;
    q_cnt_d = q_cnt_q;
    q_dir_d = q_dir_q;
    push_c  = 1'b0;
    case (state_q)
      READY: begin
        dir_d = DIR_IDLE;
        if (press_ok_c) begin
          state_d = PLAY;
          push_c  = 1'b1;
        end
      end
      PLAY: begin
        if (fatal_c) begin
          state_d = OVER;
          dir_d   = DIR_IDLE;
          q_cnt_d = '0;
        end else begin
          // Update consumes the pre-existing turn; a same-clock press lands afterwards.
          if (bus.update && (q_cnt_q != '0)) begin
            dir_d   = q_dir_q[0];
            q_cnt_d = q_cnt_q - QCW'(1);
`ifdef SNAKE_DIR_QUEUE_EN
            q_dir_d[0] = q_dir_q[1];
`endif
          end
          push_c = press_ok_c;
        end
      end
      OVER: begin
        dir_d   = DIR_IDLE;
        q_cnt_d = '0;
        if (bus.update) begin
          if (hold_q == HOLD_W'(OVER_HOLD - 1)) begin
            state_d = READY;
            hold_d  = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_d = READY;
        dir_d   = DIR_IDLE;
        q_cnt_d = '0;
        hold_d  = '0;
      end
    endcase
    if (push_c) begin
`ifdef SNAKE_DIR_QUEUE_EN
      if (q_cnt_q != QCW'(2)) begin
        q_dir_d[q_cnt_d[0]] = press_dir_c;
        q_cnt_d             = q_cnt_d + QCW'(1);
      end
`else
      q_dir_d[0] = press_dir_c;
      q_cnt_d    = QCW'(1);
`endif
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= READY;
      dir_q   <= DIR_IDLE;
      hold_q  <= '0;
      q_cnt_q <= '0;
      for (int i = 0; i < int'(QD); i++) q_dir_q[i] <= DIR_IDLE;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      q_cnt_q <= q_cnt_d;
      q_dir_q <= q_dir_d;
    end
  end

  assign bus.direction  = dir_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios then random button/tick/collision traffic,
// checked every clock against a queue-based reference model via a scoreboard.
module tb_snake_dir_ctrl;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 3;
`ifdef SNAKE_DIR_QUEUE_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [1:0] state;
    logic [2:0] dir;
    string      tag;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  snake_dir_if bus ();

  snake_dir_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_BIT        (4),
    .OVER_HOLD      (HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t     exp_q [$];
  int       n_vec = 0;
  int       n_err = 0;

  // Reference model state
  int       m_state;
  int       m_dir;
  int       m_hold;
  int       m_pend [$];
  bit [3:0] m_deb;
  bit [3:0] m_rose;
  bit [3:0] m_raw_hist [$];
  bit [3:0] m_smp [$];

  function automatic int opp(input int d);
    return ((d - 1) ^ 1) + 1;
  endfunction

  task automatic model_edge(input bit [3:0] raw, input bit upd, input bit [1:0] col, input bit rst);
    int code;
    int refd;
    bit valid;
    bit was_full;
    bit [3:0] nd;
    if (rst) begin
      m_state = 0; m_dir = 0; m_hold = 0;
      m_pend.delete(); m_raw_hist.delete(); m_smp.delete();
      m_deb = '0; m_rose = '0;
      return;
    end
    code = 0;
    for (int i = 3; i >= 0; i--) if (m_rose[i]) code = i + 1;
    refd  = (m_pend.size() > 0) ? m_pend[$] : m_dir;
    valid = (code != 0) && (refd == 0 || (code != refd && code != opp(refd)));
    case (m_state)
      0: begin
        if (valid) begin m_state = 1; m_pend = '{code}; end
      end
      1: begin
        if (col == 2'b01 || col == 2'b11) begin
          m_state = 3; m_dir = 0; m_pend.delete();
        end else begin
          was_full = (m_pend.size() >= CAP);
          if (upd && m_pend.size() > 0) m_dir = m_pend.pop_front();
          if (valid) begin
            if (CAP == 1) m_pend = '{code};
            else if (!was_full) m_pend.push_back(code);
          end
        end
      end
      default: begin
        m_dir = 0; m_pend.delete();
        if (upd) begin
          m_hold++;
          if (m_hold == int'(HOLD)) begin m_state = 0; m_hold = 0; end
        end
      end
    endcase
    // Button path: synced sample is the raw level two clocks back; a level is accepted
    // once DEB consecutive samples disagree with the current debounced level.
    m_raw_hist.push_back(raw);
    if (m_raw_hist.size() > 3) void'(m_raw_hist.pop_front());
    m_smp.push_back((m_raw_hist.size() >= 3) ? m_raw_hist[0] : 4'b0);
    if (m_smp.size() > int'(DEB)) void'(m_smp.pop_front());
    nd = m_deb;
    for (int b = 0; b < 4; b++) begin
      bit all_diff;
      all_diff = (m_smp.size() == int'(DEB));
      foreach (m_smp[k]) if (m_smp[k][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    m_rose = nd & ~m_deb;
    m_deb  = nd;
  endtask

  task automatic tick(input logic [3:0] btn, input logic upd, input logic [1:0] col,
                      input logic rst, input string tag);
    exp_t e;
    reset         = rst;
    bus.btn_up    = btn[0];
    bus.btn_down  = btn[1];
    bus.btn_left  = btn[2];
    bus.btn_right = btn[3];
    bus.update    = upd;
    bus.collision = col;
    model_edge(btn, upd, col, rst);
    e.state = 2'(m_state);
    e.dir   = 3'(m_dir);
    e.tag   = tag;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic press(input logic [3:0] m, input string tag);
    for (int i = 0; i < 8; i++) tick(m, 1'b0, 2'b00, 1'b0, tag);
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 2'b00, 1'b0, tag);
  endtask

  task automatic frame(input string tag);
    tick(4'b0000, 1'b1, 2'b00, 1'b0, tag);
    tick(4'b0000, 1'b0, 2'b00, 1'b0, tag);
  endtask

  // Scoreboard monitor: compare every registered output away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (bus.game_state !== e.state || bus.direction !== e.dir) begin
          n_err++;
          $display("FAIL %s @%0t: got state=%b dir=%b, expected state=%b dir=%b",
                   e.tag, $time, bus.game_state, bus.direction, e.state, e.dir);
        end
      end
    end
  end

  initial begin
    logic [3:0] m;
    logic       u;
    logic [1:0] col;
    int         len;
    int         r;

    tick(4'b0, 1'b0, 2'b00, 1'b1, "reset");
    tick(4'b0, 1'b0, 2'b00, 1'b1, "reset");
    tick(4'b0, 1'b0, 2'b00, 1'b0, "reset_release");

    // Bouncing UP must not register until stable
    for (int i = 0; i < 2; i++) tick(4'b0001, 1'b0, 2'b00, 1'b0, "bounce");
    for (int i = 0; i < 2; i++) tick(4'b0000, 1'b0, 2'b00, 1'b0, "bounce");
    for (int i = 0; i < 2; i++) tick(4'b0001, 1'b0, 2'b00, 1'b0, "bounce");
    for (int i = 0; i < 10; i++) tick(4'b0001, 1'b0, 2'b00, 1'b0, "bounce_hold");
    for (int i = 0; i < 8; i++) tick(4'b0000, 1'b0, 2'b00, 1'b0, "bounce_release");
    frame("first_update_up");

    // Reversal rejected
    press(4'b1000, "turn_right");
    frame("apply_right");
    press(4'b0100, "reverse_left");
    frame("reverse_rejected");

    // Simultaneous LEFT+RIGHT from UP
    press(4'b0001, "turn_up");
    frame("apply_up");
    press(4'b1100, "left_right_same_clk");
    frame("priority_left");

    // Fatal collision with update and pending DOWN in the same clock
    press(4'b0010, "pend_down");
    tick(4'b0000, 1'b1, 2'b01, 1'b0, "fatal_with_update");
    press(4'b0001, "press_in_over");
    for (int i = 0; i < 3; i++) frame("over_hold");

    // Apple collision ignored
    press(4'b0001, "restart_up");
    frame("restart_apply");
    for (int i = 0; i < 4; i++) tick(4'b0000, 1'(i % 2), 2'b10, 1'b0, "apple");

    // Two turns inside one frame
    press(4'b0100, "two_turns_left");
    press(4'b0010, "two_turns_down");
    frame("two_turns_upd1");
    frame("two_turns_upd2");

    // No update: pending held indefinitely, then reset mid-game
    press(4'b1000, "no_update");
    for (int i = 0; i < 20; i++) tick(4'b0000, 1'b0, 2'b00, 1'b0, "no_update_hold");
    tick(4'b0000, 1'b0, 2'b00, 1'b1, "mid_reset");
    frame("after_reset");

    // Random traffic
    for (int s = 0; s < 250; s++) begin
      len = $urandom_range(12, 1);
      r   = $urandom_range(5, 0);
      if (r < 2) m = 4'b0000;
      else       m = 4'(1 << $urandom_range(3, 0));
      if ($urandom_range(7, 0) == 0) m = 4'($urandom_range(15, 0));
      for (int c = 0; c < len; c++) begin
        u   = ($urandom_range(5, 0) == 0);
        r   = $urandom_range(99, 0);
        col = 2'b00;
        if (r < 2)      col = 2'b01;
        else if (r < 3) col = 2'b11;
        else if (r < 8) col = 2'b10;
        tick(m, u, col, ($urandom_range(999, 0) == 0), "random");
      end
    end

    for (int i = 0; i < 4; i++) tick(4'b0000, 1'b0, 2'b00, 1'b0, "drain");
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
